// File: rtl/if_id_pipe_if.sv
// IF->ID handshake bundle: the fetch side (if_*) and the decode side (id_*) of the pipeline stage.
// master drives fetch data and decode-ready; slave is the stage itself.
interface if_id_pipe_if #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32
);
    logic              if_valid;
    logic              if_ready;
    logic [ADDR_W-1:0] if_pc;
    logic [INST_W-1:0] if_inst;
    logic              if_err;

    logic              id_valid;
    logic              id_ready;
    logic [ADDR_W-1:0] id_pc;
    logic [INST_W-1:0] id_inst;
    logic              id_err;

    modport master (
        output if_valid, if_pc, if_inst, if_err, id_ready,
        input  if_ready, id_valid, id_pc, id_inst, id_err
    );

    modport slave (
        input  if_valid, if_pc, if_inst, if_err, id_ready,
        output if_ready, id_valid, id_pc, id_inst, id_err
    );
endinterface

// File: rtl/if_id_pipe.sv
// IF->ID stage: DEPTH-entry in-order buffer, 1-cycle push-to-head latency, no fall-through.
// if_ready depends only on occupancy; ID stalls hold the head; flush empties the buffer on the next edge.
module if_id_pipe #(
    parameter int                ADDR_W   = 32,
    parameter int                INST_W   = 32,
    parameter int                DEPTH    = 2,
    parameter logic [INST_W-1:0] NOP_INST = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    if_id_pipe_if.slave                bus,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] level
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] r_pc_mem   [DEPTH];
    logic [INST_W-1:0] r_inst_mem [DEPTH];
    logic              r_err_mem  [DEPTH];

    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [CNT_W-1:0]  r_count;

    logic              w_if_ready;
    logic              w_id_valid;
    logic              w_push;
    logic              w_pop;

    assign w_if_ready = (r_count != FULL_CNT);
    assign w_id_valid = (r_count != '0);
    assign w_push     = bus.if_valid && w_if_ready && !flush;
    assign w_pop      = w_id_valid && bus.id_ready && !flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Payload storage is not reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc_mem[r_wr_ptr]   <= bus.if_pc;
            r_inst_mem[r_wr_ptr] <= bus.if_inst;
            r_err_mem[r_wr_ptr]  <= bus.if_err;
        end
    end

    assign bus.if_ready = w_if_ready;
    assign bus.id_valid = w_id_valid;
    assign bus.id_pc    = w_id_valid ? r_pc_mem[r_rd_ptr]   : '0;
    assign bus.id_inst  = w_id_valid ? r_inst_mem[r_rd_ptr] : NOP_INST;
    assign bus.id_err   = w_id_valid ? r_err_mem[r_rd_ptr]  : 1'b0;
    assign level        = r_count;
endmodule

// File: tb/tb_if_id_pipe.sv
// Directed bench for if_id_pipe: DEPTH=2, DEPTH=3 and DEPTH=1 instances share clock and reset.
module tb_if_id_pipe;
    logic       clk = 1'b0;
    logic       rst;
    logic       fl1, fl2, fl3;
    logic [0:0] lv1;
    logic [1:0] lv2;
    logic [1:0] lv3;
    int         n_checks;
    int         n_fail;

    always #5 clk = ~clk;

    if_id_pipe_if #(.ADDR_W(32), .INST_W(32)) b1 ();
    if_id_pipe_if #(.ADDR_W(32), .INST_W(32)) b2 ();
    if_id_pipe_if #(.ADDR_W(32), .INST_W(32)) b3 ();

    if_id_pipe #(.ADDR_W(32), .INST_W(32), .DEPTH(1), .NOP_INST(32'h0000_0000)) u_d1 (
        .clk(clk), .rst(rst), .bus(b1), .flush(fl1), .level(lv1)
    );
    if_id_pipe #(.ADDR_W(32), .INST_W(32), .DEPTH(2), .NOP_INST(32'h0000_0000)) u_d2 (
        .clk(clk), .rst(rst), .bus(b2), .flush(fl2), .level(lv2)
    );
    if_id_pipe #(.ADDR_W(32), .INST_W(32), .DEPTH(3), .NOP_INST(32'h0000_0000)) u_d3 (
        .clk(clk), .rst(rst), .bus(b3), .flush(fl3), .level(lv3)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all;
        b1.if_valid = 0; b1.if_pc = '0; b1.if_inst = '0; b1.if_err = 0; b1.id_ready = 0;
        b2.if_valid = 0; b2.if_pc = '0; b2.if_inst = '0; b2.if_err = 0; b2.id_ready = 0;
        b3.if_valid = 0; b3.if_pc = '0; b3.if_inst = '0; b3.if_err = 0; b3.id_ready = 0;
        fl1 = 0; fl2 = 0; fl3 = 0;
    endtask

    task automatic test_reset;
        logic [68:0] got;
        #3;
        got = {b2.id_valid, b2.id_pc, b2.id_inst, b2.id_err, lv2, b2.if_ready};
        n_checks++;
        if (got !== {1'b0, 32'h0, 32'h0, 1'b0, 2'd0, 1'b1}) begin
            n_fail++; $display("FAIL reset_state got=%h exp=%h", got, {1'b0, 32'h0, 32'h0, 1'b0, 2'd0, 1'b1});
        end
        n_checks++;
        if ({b1.if_ready, b3.if_ready, b1.id_valid, b3.id_valid} !== 4'b1100) begin
            n_fail++; $display("FAIL reset_other got=%b exp=1100", {b1.if_ready, b3.if_ready, b1.id_valid, b3.id_valid});
        end
        @(negedge clk) rst = 1;
        step;
        b2.if_valid = 1; b2.if_pc = 32'hE0; b2.if_inst = 32'h1111_0000;
        step;
        b2.if_pc = 32'hE4; b2.if_inst = 32'h1111_0004;
        step;
        b2.if_valid = 0;
        #1;
        n_checks++;
        if ({lv2, b2.if_ready, b2.id_pc} !== {2'd2, 1'b0, 32'hE0}) begin
            n_fail++; $display("FAIL prereset_full got=%h exp=%h", {lv2, b2.if_ready, b2.id_pc}, {2'd2, 1'b0, 32'hE0});
        end
        rst = 0;
        #1;
        got = {b2.id_valid, b2.id_pc, b2.id_inst, b2.id_err, lv2, b2.if_ready};
        n_checks++;
        if (got !== {1'b0, 32'h0, 32'h0, 1'b0, 2'd0, 1'b1}) begin
            n_fail++; $display("FAIL async_reset got=%h exp=%h", got, {1'b0, 32'h0, 32'h0, 1'b0, 2'd0, 1'b1});
        end
        @(negedge clk) rst = 1;
        step;
        n_checks++;
        if ({b2.id_valid, lv2} !== 3'b000) begin
            n_fail++; $display("FAIL reset_entries_lost got=%b exp=000", {b2.id_valid, lv2});
        end
    endtask

    task automatic test_streaming;
        b2.id_ready = 1;
        for (int i = 0; i < 3; i++) begin
            b2.if_valid = 1;
            b2.if_pc    = 32'h100 + 32'(4 * i);
            b2.if_inst  = 32'h2000_0000 + 32'(i);
            step;
            n_checks++;
            if ({b2.id_valid, b2.id_pc, b2.id_inst, lv2} !== {1'b1, 32'h100 + 32'(4 * i), 32'h2000_0000 + 32'(i), 2'd1}) begin
                n_fail++; $display("FAIL stream_%0d got v=%b pc=%h inst=%h lvl=%0d exp pc=%h lvl=1",
                                   i, b2.id_valid, b2.id_pc, b2.id_inst, lv2, 32'h100 + 32'(4 * i));
            end
        end
        b2.if_valid = 0;
        step;
        n_checks++;
        if ({b2.id_valid, lv2} !== 3'b000) begin
            n_fail++; $display("FAIL stream_drain got=%b exp=000", {b2.id_valid, lv2});
        end
        b2.id_ready = 0;
    endtask

    task automatic test_backpressure;
        b2.id_ready = 0;
        b2.if_valid = 1; b2.if_pc = 32'h200;
        step;
        n_checks++;
        if ({lv2, b2.if_ready} !== 3'b011) begin
            n_fail++; $display("FAIL bp_first got=%b exp=011", {lv2, b2.if_ready});
        end
        b2.if_pc = 32'h204;
        step;
        n_checks++;
        if ({lv2, b2.if_ready} !== 3'b100) begin
            n_fail++; $display("FAIL bp_full got=%b exp=100", {lv2, b2.if_ready});
        end
        b2.if_pc = 32'h208;
        step;
        n_checks++;
        if ({lv2, b2.id_pc} !== {2'd2, 32'h200}) begin
            n_fail++; $display("FAIL bp_hold got=%h exp=%h", {lv2, b2.id_pc}, {2'd2, 32'h200});
        end
        b2.id_ready = 1;
        #1;
        n_checks++;
        if ({b2.id_pc, b2.if_ready} !== {32'h200, 1'b0}) begin
            n_fail++; $display("FAIL bp_out0 got=%h exp=%h", {b2.id_pc, b2.if_ready}, {32'h200, 1'b0});
        end
        step;
        n_checks++;
        if ({b2.id_pc, b2.if_ready} !== {32'h204, 1'b1}) begin
            n_fail++; $display("FAIL bp_out1 got=%h exp=%h", {b2.id_pc, b2.if_ready}, {32'h204, 1'b1});
        end
        step;
        b2.if_valid = 0;
        n_checks++;
        if ({b2.id_valid, b2.id_pc, lv2} !== {1'b1, 32'h208, 2'd1}) begin
            n_fail++; $display("FAIL bp_out2 got=%h exp=%h", {b2.id_valid, b2.id_pc, lv2}, {1'b1, 32'h208, 2'd1});
        end
        step;
        n_checks++;
        if (b2.id_valid !== 1'b0) begin
            n_fail++; $display("FAIL bp_drain got=%b exp=0", b2.id_valid);
        end
        b2.id_ready = 0;
    endtask

    task automatic test_flush;
        b2.id_ready = 0;
        b2.if_valid = 1; b2.if_pc = 32'h2F0; b2.if_inst = 32'h3000_0000;
        step;
        b2.if_pc = 32'h2F4; b2.if_inst = 32'h3000_0004;
        step;
        n_checks++;
        if (lv2 !== 2'd2) begin
            n_fail++; $display("FAIL flush_prefill got=%0d exp=2", lv2);
        end
        fl2 = 1; b2.if_pc = 32'h300; b2.if_inst = 32'h3000_0300; b2.id_ready = 1;
        step;
        fl2 = 0; b2.if_valid = 0;
        n_checks++;
        if ({b2.id_valid, lv2, b2.id_inst, b2.id_pc, b2.if_ready} !== {1'b0, 2'd0, 32'h0, 32'h0, 1'b1}) begin
            n_fail++; $display("FAIL flush_full got=%h exp=%h",
                               {b2.id_valid, lv2, b2.id_inst, b2.id_pc, b2.if_ready}, {1'b0, 2'd0, 32'h0, 32'h0, 1'b1});
        end
        for (int i = 0; i < 3; i++) begin
            step;
            n_checks++;
            if (b2.id_valid !== 1'b0) begin
                n_fail++; $display("FAIL flush_no_ghost_%0d got pc=%h exp id_valid=0", i, b2.id_pc);
            end
        end
        b2.id_ready = 0;
        b2.if_valid = 1; b2.if_pc = 32'h310;
        step;
        fl2 = 1; b2.if_pc = 32'h314;
        step;
        fl2 = 0;
        n_checks++;
        if ({b2.id_valid, lv2} !== 3'b000) begin
            n_fail++; $display("FAIL flush_partial got=%b exp=000", {b2.id_valid, lv2});
        end
        b2.if_pc = 32'h320;
        step;
        b2.if_valid = 0;
        n_checks++;
        if ({b2.id_valid, b2.id_pc, lv2} !== {1'b1, 32'h320, 2'd1}) begin
            n_fail++; $display("FAIL flush_repush got=%h exp=%h", {b2.id_valid, b2.id_pc, lv2}, {1'b1, 32'h320, 2'd1});
        end
        b2.id_ready = 1;
        step;
        b2.id_ready = 0;
        n_checks++;
        if (lv2 !== 2'd0) begin
            n_fail++; $display("FAIL flush_repush_drain got=%0d exp=0", lv2);
        end
    endtask

    task automatic test_wrap_fault;
        logic [31:0] rdy_pat;
        int          sent;
        int          recv;
        int          max_lvl;
        rdy_pat = 32'hFFFF_F2D0;
        sent = 0; recv = 0; max_lvl = 0;
        for (int cyc = 0; cyc < 60 && recv < 7; cyc++) begin
            b3.if_valid = (sent < 7);
            b3.if_pc    = 32'h400 + 32'(4 * sent);
            b3.if_inst  = 32'hA000_0000 + 32'(sent);
            b3.if_err   = (sent == 4);
            b3.id_ready = (cyc < 32) ? rdy_pat[cyc] : 1'b1;
            #1;
            if (b3.id_valid && b3.id_ready) begin
                n_checks++;
                if ({b3.id_pc, b3.id_inst, b3.id_err} !== {32'h400 + 32'(4 * recv), 32'hA000_0000 + 32'(recv), recv == 4}) begin
                    n_fail++; $display("FAIL wrap_entry_%0d got pc=%h inst=%h err=%b exp pc=%h err=%b",
                                       recv, b3.id_pc, b3.id_inst, b3.id_err, 32'h400 + 32'(4 * recv), recv == 4);
                end
                recv++;
            end
            n_checks++;
            if (lv3 > 2'd3 || lv3 === 2'bxx) begin
                n_fail++; $display("FAIL wrap_level got=%0d exp<=3", lv3);
            end
            if (int'(lv3) > max_lvl) max_lvl = int'(lv3);
            if (b3.if_valid && b3.if_ready) sent++;
            step;
        end
        b3.if_valid = 0; b3.if_err = 0; b3.id_ready = 0;
        n_checks++;
        if (recv != 7) begin
            n_fail++; $display("FAIL wrap_delivered got=%0d exp=7", recv);
        end
        n_checks++;
        if (max_lvl != 3) begin
            n_fail++; $display("FAIL wrap_max_level got=%0d exp=3", max_lvl);
        end
    endtask

    task automatic test_depth1;
        int sent;
        int recv;
        sent = 0; recv = 0;
        b1.id_ready = 1;
        for (int c = 0; c < 8; c++) begin
            b1.if_valid = 1;
            b1.if_pc    = 32'h500 + 32'(4 * sent);
            #1;
            n_checks++;
            if ({b1.if_ready, b1.id_valid} !== {(c % 2) == 0, (c % 2) == 1}) begin
                n_fail++; $display("FAIL d1_alternate_%0d got=%b%b exp=%b%b", c, b1.if_ready, b1.id_valid,
                                   (c % 2) == 0, (c % 2) == 1);
            end
            if (b1.id_valid) begin
                n_checks++;
                if (b1.id_pc !== 32'h500 + 32'(4 * recv)) begin
                    n_fail++; $display("FAIL d1_order_%0d got=%h exp=%h", recv, b1.id_pc, 32'h500 + 32'(4 * recv));
                end
                recv++;
            end
            if (b1.if_valid && b1.if_ready) sent++;
            step;
        end
        b1.if_valid = 0; b1.id_ready = 0;
        n_checks++;
        if (recv != 4) begin
            n_fail++; $display("FAIL d1_throughput got=%0d exp=4", recv);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 0;
        idle_all();
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_wrap_fault();
        test_depth1();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
